contador_palabras: RTL and testbench

// Responder side of the transaction-layer counter-read interface: counts words actually popped from

---
 rtl/contador_palabras_pkg.sv | 26 ++
 rtl/contador_palabras_if.sv | 33 +++
 rtl/contador_palabras_unidad.sv | 39 +++
 rtl/contador_palabras.sv | 80 ++++++++
 tb/tb_contador_palabras.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/contador_palabras_pkg.sv
// Shared parameters, read-FSM state encoding and the pop-count helper for the
// contador_palabras word-counter block. The transaction FSM and the tester use
// the same encodings.
package contador_palabras_pkg;

  localparam int FIFO_UNITS = 4;
  localparam int INDEX      = 2;
  localparam int CNT_W      = 5;
  localparam int TOT_W      = 7;

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_SERVE = 1'b1
  } estado_t;

  // Number of qualified pops in one cycle, widened to the aggregate width.
  function automatic logic [TOT_W-1:0] popcount(input logic [FIFO_UNITS-1:0] v);
    logic [TOT_W-1:0] s;
    s = '0;
    for (int i = 0; i < FIFO_UNITS; i++) begin
      s = s + TOT_W'(v[i]);
    end
    return s;
  endfunction

endpackage

// File: rtl/contador_palabras_if.sv
// Counter-read bus between the output-FIFO stage / tester and contador_palabras.
//   init        sync clear of all counters
//   pop, empty  per-FIFO pop request and empty flag
//   idle        transaction FSM in IDLE; reads only served while high
//   req, idx    level-held read request and selected counter
//   valid       cuenta holds a served read
//   cuenta      value of the selected counter
//   contador_4  live aggregate of all qualified pops
// master = tester/FIFO side, slave = counter block.
interface contador_palabras_if;
  import contador_palabras_pkg::*;

  logic                  init;
  logic [FIFO_UNITS-1:0] pop;
  logic [FIFO_UNITS-1:0] empty;
  logic                  idle;
  logic                  req;
  logic [INDEX-1:0]      idx;
  logic                  valid;
  logic [CNT_W-1:0]      cuenta;
  logic [TOT_W-1:0]      contador_4;

  modport master (
    output init, pop, empty, idle, req, idx,
    input  valid, cuenta, contador_4
  );

  modport slave (
    input  init, pop, empty, idle, req, idx,
    output valid, cuenta, contador_4
  );

endinterface

// File: rtl/contador_palabras_unidad.sv
// Single per-FIFO word counter, wraps modulo 2^CNT_W.
//   clk    rising-edge clock
//   reset  async active-high clear
//   init   sync clear, wins over inc
//   inc    qualified pop this cycle
//   count  current count
module contador_unidad
  import contador_palabras_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (init) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/contador_palabras.sv
// Responder side of the counter-read interface: counts words popped from each
// output FIFO, keeps a live aggregate, and returns a selected count on request.
//   clk    rising-edge clock
//   reset  async active-high clear of every flop
//   bus    contador_palabras_if slave port (see interface header)
//
// Read FSM
//   state    | meaning
//   ST_WAIT  | no read served; valid=0, cuenta holds its last value
//   ST_SERVE | read served; valid=1, cuenta tracks cnt[idx] one cycle late
module contador_palabras
  import contador_palabras_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  contador_palabras_if.slave bus
);

  logic [FIFO_UNITS-1:0] inc;
  logic [CNT_W-1:0]      cnt [FIFO_UNITS];

  logic [TOT_W-1:0] total_q,  total_d;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;
  estado_t          state_q,  state_d;
  logic             serve_ok;

  // An empty FIFO ignores the pop, so it must not be counted either.
  assign inc = bus.pop & ~bus.empty;

  for (genvar g = 0; g < FIFO_UNITS; g++) begin : g_unidad
    contador_unidad u_unidad (
      .clk   (clk),
      .reset (reset),
      .init  (bus.init),
      .inc   (inc[g]),
      .count (cnt[g])
    );
  end

  always_comb begin
    total_d = total_q + popcount(inc);
    if (bus.init) begin
      total_d = '0;
    end
  end

  // Entry into SERVE and staying in SERVE share the same condition.
  assign serve_ok = bus.req & bus.idle & ~bus.init;

  always_comb begin
    state_d  = state_q;
    cuenta_d = cuenta_q;
    case (state_q)
      ST_WAIT:  if (serve_ok)  state_d = ST_SERVE;
      ST_SERVE: if (!serve_ok) state_d = ST_WAIT;
      default:  state_d = ST_WAIT;
    endcase
    // Counter value sampled before this edge's pops land.
    if (state_d == ST_SERVE) begin
      cuenta_d = cnt[bus.idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q  <= '0;
      cuenta_q <= '0;
      state_q  <= ST_WAIT;
    end else begin
      total_q  <= total_d;
      cuenta_q <= cuenta_d;
      state_q  <= state_d;
    end
  end

  assign bus.valid      = (state_q == ST_SERVE);
  assign bus.cuenta     = cuenta_q;
  assign bus.contador_4 = total_q;

endmodule

// File: tb/tb_contador_palabras.sv
module tb_contador_palabras;

  logic clk;
  logic reset;

  contador_palabras_if bus_if ();

  contador_palabras dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: plain integer tallies of qualified pops since the last clear.
  int      pops_m [4];
  int      total_m;
  int      exp_q [$];
  int      hold_m;
  logic    exp_valid;
  logic [3:0] qual_m;
  logic    serve_m;

  task automatic check(input string name, input int act, input int req_v);
    n_vec++;
    if (act != req_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req_v);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) pops_m[i] = 0;
      total_m   = 0;
      hold_m    = 0;
      exp_valid = 1'b0;
      exp_q.delete();
    end else begin
      qual_m  = bus_if.pop & ~bus_if.empty;
      serve_m = bus_if.req && bus_if.idle && !bus_if.init;
      if (serve_m) begin
        hold_m = pops_m[bus_if.idx] % 32;
        exp_q.push_back(hold_m);
      end
      exp_valid = serve_m;
      if (bus_if.init) begin
        for (int i = 0; i < 4; i++) pops_m[i] = 0;
        total_m = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (qual_m[i]) begin
            pops_m[i] = (pops_m[i] + 1) % 1024;
            total_m   = (total_m + 1) % 1024;
          end
        end
      end
    end
  end

  // Monitor: pops an expected read whenever the DUT presents valid.
  always @(negedge clk) begin
    int e;
    check("valid", int'(bus_if.valid), int'(exp_valid));
    check("contador_4", int'(bus_if.contador_4), total_m % 128);
    if (bus_if.valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL cuenta_unexpected at %0t: got valid with %0d, expected no read", $time, bus_if.cuenta);
      end else begin
        e = exp_q.pop_front();
        check("cuenta", int'(bus_if.cuenta), e);
      end
    end else begin
      check("cuenta_hold", int'(bus_if.cuenta), hold_m);
    end
  end

  task automatic step(input logic [3:0] p, input logic [3:0] e, input logic rq,
                      input logic [1:0] ix, input logic idl, input logic in);
    bus_if.pop   = p;
    bus_if.empty = e;
    bus_if.req   = rq;
    bus_if.idx   = ix;
    bus_if.idle  = idl;
    bus_if.init  = in;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    step(4'b0, 4'b0, 1'b0, 2'd0, 1'b1, 1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus_if.pop = '0; bus_if.empty = '0; bus_if.req = 1'b0;
    bus_if.idx = '0; bus_if.idle = 1'b1; bus_if.init = 1'b0;
    #3;
    check("reset_valid", int'(bus_if.valid), 0);
    check("reset_cuenta", int'(bus_if.cuenta), 0);
    check("reset_contador_4", int'(bus_if.contador_4), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Fresh counters, sweep idx with req held.
    for (int i = 0; i < 4; i++) step(4'b0, 4'b0, 1'b1, 2'(i), 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b0, 2'd0, 1'b1, 1'b0);

    // All four FIFOs popped for 6 cycles, then sweep.
    for (int i = 0; i < 6; i++) step(4'b1111, 4'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0, 4'b0, 1'b1, 2'(i), 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b0, 2'd0, 1'b1, 1'b0);

    // Pop on empty S1 is not counted.
    clear_all();
    step(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b0010, 4'b0010, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b1, 2'd1, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b0, 2'd1, 1'b1, 1'b0);

    // Per-counter and aggregate wrap.
    clear_all();
    for (int i = 0; i < 33; i++) step(4'b0100, 4'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b1, 2'd2, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b0, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 95; i++) step(4'b0100, 4'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b1, 2'd2, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b0, 2'd2, 1'b1, 1'b0);

    // req while not idle is ignored until idle rises; init ends the read.
    clear_all();
    step(4'b1000, 4'b0, 1'b0, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0, 4'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    step(4'b0, 4'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b1, 2'd3, 1'b1, 1'b1);
    step(4'b0, 4'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b0, 2'd3, 1'b1, 1'b0);

    // Read and pop at the same edge: pre-update value first.
    clear_all();
    for (int i = 0; i < 3; i++) step(4'b0001, 4'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b0001, 4'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b1, 2'd0, 1'b1, 1'b0);

    // Async reset in the middle of a served read.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid", int'(bus_if.valid), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(4'b0, 4'b0, 1'b0, 2'd0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 4'($urandom) & 4'($urandom),
           1'($urandom_range(0, 3) != 0), 2'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
    end
    step(4'b0, 4'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    step(4'b0, 4'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
